// File: rtl/wshb_pkg.sv
// Shared Wishbone definitions: cycle-type / burst-type codes and the
// slave state encoding used by wshb_ram_slave.
package wshb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

endpackage

// File: rtl/wshb_ram_bytes.sv
// DEPTH x (8*BYTES) RAM with per-byte write enables and a registered read
// port. A write and a read of the same word in one cycle returns the
// freshly written bytes, so back-to-back burst beats never see stale data.
module wshb_ram_bytes #(
  parameter int DEPTH = 1024,
  parameter int BYTES = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_idx,
  input  logic [8*BYTES-1:0] wr_data,
  input  logic [BYTES-1:0]   wr_sel,
  input  logic [AW-1:0]      rd_idx,
  output logic [8*BYTES-1:0] rd_data
);

  logic [8*BYTES-1:0] mem [DEPTH];
  logic [8*BYTES-1:0] fwd;

  // Byte-lane writes; storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_sel[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Merge same-cycle write bytes into the word being read (write-first).
  always_comb begin
    fwd = mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_sel[b]) begin
          fwd[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Registered read port, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= fwd;
    end
  end

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 RAM slave with registered ack/err.
// Optional feature macro: WSHB_RAM_BURST_EN enables incrementing linear
// bursts (cti=010, bte=00). Without it every access is a single beat and
// the BURST state has no logic behind it.
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_BYTES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_ms,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [32:0]   ADR_LIMIT = 33'(DEPTH) << 2;
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] adr_idx;
  logic          ack_d, err_d;
  logic          wr_en, ram_wr_en;
  logic          beat_live;
  logic          bad_adr;
  logic          burst_req;

  assign adr_idx   = adr[AW+1:2];
  assign bad_adr   = (adr[1:0] != 2'b00) || ({1'b0, adr} >= ADR_LIMIT);
  assign beat_live = cyc & stb;
  assign rty       = 1'b0;

`ifdef WSHB_RAM_BURST_EN
  assign burst_req = (cti == CTI_INCR) && (bte == BTE_LINEAR);
`else
  logic unused_burst_ctl;
  assign burst_req        = 1'b0;
  assign unused_burst_ctl = ^{cti, bte};
`endif

  // Next-state, handshake and RAM-port decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      ST_IDLE: begin
        // Read is issued with the bus address so data lands with ack.
        rd_idx = adr_idx;
        if (beat_live && !ack && !err) begin
          idx_d   = adr_idx;
          state_d = ST_SINGLE;
          if (bad_adr) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (burst_req) begin
              state_d = ST_BURST;
            end
          end
        end
      end
      ST_SINGLE: begin
        // The beat completes now; a master that already dropped cyc/stb
        // still sees the ack but its data is not stored.
        wr_en   = ack && we && beat_live;
        state_d = ST_IDLE;
      end
`ifdef WSHB_RAM_BURST_EN
      ST_BURST: begin
        if (beat_live) begin
          wr_en = we;
          if (cti == CTI_EOB) begin
            state_d = ST_IDLE;
          end else begin
            ack_d  = 1'b1;
            idx_d  = idx_q + IDX_ONE;
            rd_idx = idx_q + IDX_ONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched word index and registered terminations.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack     <= ack_d;
      err     <= err_d;
    end
  end

  // Reset blocks any write on the edge where it is sampled.
  assign ram_wr_en = wr_en & sys_rst;

  wshb_ram_bytes #(
    .DEPTH (DEPTH),
    .BYTES (DATA_BYTES),
    .AW    (AW)
  ) u_ram (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .wr_en   (ram_wr_en),
    .wr_idx  (idx_q),
    .wr_data (dat_ms),
    .wr_sel  (sel),
    .rd_idx  (rd_idx),
    .rd_data (dat_sm)
  );

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Self-checking bench for wshb_ram_slave: per-cycle vector table for
// classic, byte-enable, error and cyc-drop cases, plus hand sequences for
// bursts and reset during a burst. Works with and without WSHB_RAM_BURST_EN.
module tb_wshb_ram_slave;
  import wshb_pkg::*;

`ifdef WSHB_RAM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk;
  logic        sys_rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err, rty;

  int checks   = 0;
  int failures = 0;

  wshb_ram_slave dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .cyc     (cyc),
    .stb     (stb),
    .we      (we),
    .adr     (adr),
    .dat_ms  (dat_ms),
    .sel     (sel),
    .cti     (cti),
    .bte     (bte),
    .dat_sm  (dat_sm),
    .ack     (ack),
    .err     (err),
    .rty     (rty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  t;
    logic        e_ack;
    logic        e_err;
    logic        chk_q;
    logic [31:0] e_q;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic w, logic [31:0] a,
                              logic [31:0] d, logic [3:0] s, logic [2:0] t,
                              logic ea, logic ee, logic ck, logic [31:0] q);
    vec_t v;
    v.rst = r; v.cs = c; v.w = w; v.a = a; v.d = d; v.s = s; v.t = t;
    v.e_ack = ea; v.e_err = ee; v.chk_q = ck; v.e_q = q;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; cti = CTI_CLASSIC;
  endtask

  // Master beat: hold the request until ack/err is seen before an edge;
  // n = edges consumed (99 on timeout), q = read data seen with the ack.
  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] s, input logic [2:0] t,
                      output int n, output logic [31:0] q, output logic e);
    logic sa, se;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s; cti = t;
    bte = BTE_LINEAR;
    n = 0; q = '0; e = 1'b0; sa = 1'b0; se = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sa = ack; se = err; q = dat_sm;
      @(posedge clk);
      #1;
      n++;
      if (sa || se) break;
    end
    e = se;
    if (!(sa || se)) n = 99;
  endtask

  initial begin
    int          n;
    logic [31:0] q;
    logic        e;

    sys_rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_ms = '0; sel = '0; cti = CTI_CLASSIC; bte = BTE_LINEAR;

    //            rst cs w  adr       dat           sel   cti         ack err chk q
    vecs.push_back(mk(0, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h10,   32'h12345678, 4'hF, CTI_CLASSIC, 0, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h10,   32'hDEADBEEF, 4'hF, CTI_CLASSIC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h10,   32'hDEADBEEF, 4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h10,   32'h0,        4'hF, CTI_CLASSIC, 1, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 0, 32'h10,   32'h0,        4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h10,   32'h0,        4'hF, CTI_CLASSIC, 1, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 0, 32'h10,   32'h0,        4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h10,   32'h000000AA, 4'h1, CTI_CLASSIC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h10,   32'h000000AA, 4'h1, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h10,   32'h0,        4'hF, CTI_CLASSIC, 1, 0, 1, 32'hDEADBEAA));
    vecs.push_back(mk(1, 1, 0, 32'h10,   32'h0,        4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h0,    32'hCAFEF00D, 4'hF, CTI_CLASSIC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h0,    32'hCAFEF00D, 4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h204,  32'h55555555, 4'hF, CTI_CLASSIC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h204,  32'h55555555, 4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h1002, 32'h0,        4'hF, CTI_INCR,    0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h1002, 32'h0,        4'hF, CTI_INCR,    0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h1000, 32'h12345678, 4'hF, CTI_CLASSIC, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h1000, 32'h12345678, 4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,    32'h0,        4'hF, CTI_CLASSIC, 1, 0, 1, 32'hCAFEF00D));
    vecs.push_back(mk(1, 1, 0, 32'h0,    32'h0,        4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h8,    32'h22222222, 4'hF, CTI_CLASSIC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h8,    32'h22222222, 4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h8,    32'h11111111, 4'hF, CTI_CLASSIC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 32'h8,    32'h11111111, 4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h8,    32'h0,        4'hF, CTI_CLASSIC, 1, 0, 1, 32'h22222222));
    vecs.push_back(mk(1, 1, 0, 32'h8,    32'h0,        4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h8,    32'hFFFFFFFF, 4'h0, CTI_CLASSIC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h8,    32'hFFFFFFFF, 4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h8,    32'h0,        4'hF, CTI_CLASSIC, 1, 0, 1, 32'h22222222));
    vecs.push_back(mk(1, 1, 0, 32'h8,    32'h0,        4'hF, CTI_CLASSIC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    32'h0,        4'h0, CTI_CLASSIC, 0, 0, 0, 32'h0));

    foreach (vecs[i]) begin
      sys_rst = vecs[i].rst;
      cyc     = vecs[i].cs;
      stb     = vecs[i].cs;
      we      = vecs[i].w;
      adr     = vecs[i].a;
      dat_ms  = vecs[i].d;
      sel     = vecs[i].s;
      cti     = vecs[i].t;
      tick();
      check($sformatf("row%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
      check($sformatf("row%0d_err", i), 32'(err), 32'(vecs[i].e_err));
      if (vecs[i].chk_q) check($sformatf("row%0d_dat", i), dat_sm, vecs[i].e_q);
      check($sformatf("row%0d_rty", i), 32'(rty), 32'h0);
    end

    // Four-beat write then read at 0x100; bursts pace 2,1,1,1 edges,
    // single-beat fallback paces every beat at 2 edges.
    for (int i = 0; i < 4; i++) begin
      beat(32'h100 + 32'(4*i), 32'(i+1), 1'b1, 4'hF, (i == 3) ? CTI_EOB : CTI_INCR, n, q, e);
      check($sformatf("bw%0d_cycles", i), 32'(n), (i == 0) ? 32'd2 : (BURST ? 32'd1 : 32'd2));
      check($sformatf("bw%0d_err", i), 32'(e), 32'h0);
    end
    bus_idle();
    check("bw_ack_after_last", 32'(ack), 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      beat(32'h100 + 32'(4*i), 32'h0, 1'b0, 4'hF, (i == 3) ? CTI_EOB : CTI_INCR, n, q, e);
      check($sformatf("br%0d_cycles", i), 32'(n), (i == 0) ? 32'd2 : (BURST ? 32'd1 : 32'd2));
      check($sformatf("br%0d_data", i), q, 32'(i+1));
    end
    bus_idle();
    check("br_ack_after_last", 32'(ack), 32'h0);
    tick();

    // Reset while beat 2 of a write burst is on the bus.
    beat(32'h200, 32'h000000A1, 1'b1, 4'hF, CTI_INCR, n, q, e);
    check("rst_beat1_cycles", 32'(n), 32'd2);
    adr = 32'h204; dat_ms = 32'h000000A2; cti = CTI_INCR; sys_rst = 1'b0;
    tick();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_dat", dat_sm, 32'h0);
    sys_rst = 1'b1;
    bus_idle();
    tick();
    check("rst_ack_idle", 32'(ack), 32'h0);
    beat(32'h200, 32'h0, 1'b0, 4'hF, CTI_CLASSIC, n, q, e);
    check("rst_rd0_cycles", 32'(n), 32'd2);
    check("rst_rd0_data", q, 32'h000000A1);
    beat(32'h204, 32'h0, 1'b0, 4'hF, CTI_CLASSIC, n, q, e);
    check("rst_rd1_data", q, 32'h55555555);
    bus_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wshb_ram_slave.md
WSHB_RAM_SLAVE -- requirements
Module: wshb_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter DATA_BYTES, default 4, Wishbone data width in bytes; only 4 is supported.
REQ-003 sys_clk  in  1  single system clock; all logic rises on its positive edge.
REQ-004 sys_rst  in  1  reset, synchronous, active-low.
REQ-005 cyc  in  1  Wishbone cycle valid.
REQ-006 stb  in  1  Wishbone strobe, request valid.
REQ-007 we  in  1  1 = write, 0 = read.
REQ-008 adr  in  32  byte address.
REQ-009 dat_ms  in  32  write data, master to slave.
REQ-010 sel  in  4  byte enables; bit i covers dat_ms[8i+7:8i].
REQ-011 cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
REQ-012 bte  in  2  burst type; only 00 (linear) is supported.
REQ-013 dat_sm  out  32  read data, slave to master.
REQ-014 ack  out  1  normal termination of one beat.
REQ-015 err  out  1  error termination of one beat.
REQ-016 rty  out  1  retry; tied to 0.

Function
REQ-017 A request SHALL be cyc&stb high at a rising edge while ack and err are low, or while in BURST.
REQ-018 State machine SHALL have states IDLE, SINGLE and BURST.
REQ-019 IDLE + request: word index adr[log2(DEPTH)+1:2] SHALL be latched; ack or err SHALL rise the next cycle; state SHALL go to BURST if cti=010 and bte=00, else to SINGLE.
REQ-020 SINGLE: ack/err SHALL be high exactly one cycle, then the block SHALL return to IDLE; a classic request therefore spans at least 2 cycles, with an idle gap before the next one.
REQ-021 BURST: while cyc&stb is high, ack SHALL stay high every cycle and the word index SHALL increment by 1 per beat, modulo DEPTH.
REQ-022 BURST SHALL exit to IDLE after the beat acked with cti=111, or when cyc or stb is low; ack SHALL then be 0 on the following cycle.
REQ-023 Write: on each cycle with ack=1 and we=1, the bytes enabled by sel SHALL be written; sel=0000 SHALL write nothing but still ack.
REQ-024 Read: dat_sm SHALL hold the addressed word during every cycle in which ack=1 (1-cycle synchronous RAM read, address issued one cycle ahead).
REQ-025 Read-after-write to the same word in consecutive burst beats SHALL return the new data.
REQ-026 err SHALL replace ack when adr[1:0]!=00 or adr >= 4*DEPTH; no write SHALL occur and the block SHALL go to SINGLE, even if cti=010.
REQ-027 ack and err SHALL never be high in the same cycle.
REQ-028 cyc dropping while in SINGLE SHALL NOT suppress the already scheduled ack, but SHALL suppress the write.

Reset
REQ-029 With sys_rst=0 at a clock edge: state=IDLE, ack=0, err=0, dat_sm=0, latched index=0.
REQ-030 Reset mid-burst SHALL abort on the next edge with no further write; RAM contents SHALL NOT be cleared.

Configuration
REQ-031 Macro WSHB_RAM_BURST_EN defined: behaviour SHALL be as in REQ-021/022.
REQ-032 Macro WSHB_RAM_BURST_EN absent: cti and bte SHALL be ignored, every access SHALL use SINGLE, and BURST SHALL not be synthesized.

Structure
REQ-033 Shared package wshb_pkg SHALL hold the cti codes (CTI_CLASSIC, CTI_INCR, CTI_EOB), the bte code BTE_LINEAR and the state enum type.
REQ-034 Sub-module wshb_ram_bytes SHALL implement the DEPTH x 32 RAM with 4 byte-write enables and a registered read port.

Verification
REQ-035 Classic write adr=0x10, dat_ms=0xDEADBEEF, sel=1111, then classic read adr=0x10 -> ack 1 cycle after each request, dat_sm=0xDEADBEEF, gap of 1 cycle with ack=0.
REQ-036 Byte write adr=0x10, dat_ms=0x000000AA, sel=0001 over 0xDEADBEEF -> read returns 0xDEADBEAA.
REQ-037 Burst (BURST_EN), 4 writes from adr=0x100 (cti 010,010,010,111), data 1..4, then 4-beat read burst -> ack high 4 consecutive cycles each time, read data 1,2,3,4, ack=0 after the last beat.
REQ-038 Read adr=0x1002 and adr=4*DEPTH -> err=1 for 1 cycle, ack=0, memory unchanged.
REQ-039 sys_rst=0 on the 2nd beat of a 4-beat write burst -> ack=0 next cycle, only beat 1 written, state IDLE.
REQ-040 Without BURST_EN, same stimulus as REQ-037 -> each beat acked singly with a 1-cycle gap, data correct.
